// File: rtl/regbank_wr_arbiter.sv
// Round-robin write-port arbiter for a single-write-port register bank.
// Define REGBANK_WR_ARB_SCOREBOARD_EN to build the per-register busy scoreboard.
module regbank_wr_arbiter #(
    parameter int unsigned Index_size = 4,
    parameter int unsigned width      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [Index_size-1:0]      req0_rd,
    input  logic [width-1:0]           req0_wd,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [Index_size-1:0]      req1_rd,
    input  logic [width-1:0]           req1_wd,
    output logic                       req1_ready,
    output logic                       WE,
    output logic [Index_size-1:0]      Rd,
    output logic [width-1:0]           WD,
    output logic                       grant_id,
    input  logic                       rsv_valid,
    input  logic [Index_size-1:0]      rsv_rd,
    output logic [2**Index_size-1:0]   busy
);

    localparam int unsigned NumRegs = 2 ** Index_size;

    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [Index_size-1:0] rd_q, rd_d;
    logic [width-1:0]      wd_q, wd_d;
    logic                  gid_q, gid_d;

    logic                  xfer;
    logic                  win_id;
    logic [Index_size-1:0] win_rd;
    logic [width-1:0]      win_wd;

    // On a tie the requester that was not granted last wins; nothing is ready in reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_q;
                req1_ready = ~last_q;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign xfer   = req0_ready | req1_ready;
    assign win_id = req1_ready;
    assign win_rd = win_id ? req1_rd : req0_rd;
    assign win_wd = win_id ? req1_wd : req0_wd;

    always_comb begin
        last_d = last_q;
        we_d   = 1'b0;
        rd_d   = rd_q;
        wd_d   = wd_q;
        gid_d  = gid_q;
        if (xfer) begin
            last_d = win_id;
            we_d   = (win_rd != '0);
            rd_d   = win_rd;
            wd_d   = win_wd;
            gid_d  = win_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
            we_q   <= 1'b0;
            rd_q   <= '0;
            wd_q   <= '0;
            gid_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            rd_q   <= rd_d;
            wd_q   <= wd_d;
            gid_q  <= gid_d;
        end
    end

    assign WE       = we_q;
    assign Rd       = rd_q;
    assign WD       = wd_q;
    assign grant_id = gid_q;

`ifdef REGBANK_WR_ARB_SCOREBOARD_EN
    logic [NumRegs-1:0] busy_q, busy_d;

    // Reserve is applied after clear so a newer pending writer keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[win_rd] = 1'b0;
        end
        if (rsv_valid) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_rd};
    assign busy       = {NumRegs{1'b0}};
`endif

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: behavioural model compared every falling edge,
// plus directed literal checks and a model of the 16x32 register bank.
module tb_regbank_wr_arbiter;

`ifdef REGBANK_WR_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_rd = '0, req1_rd = '0;
    logic [31:0] req0_wd = '0, req1_wd = '0;
    logic        req0_ready, req1_ready;
    logic        WE;
    logic [3:0]  Rd;
    logic [31:0] WD;
    logic        grant_id;
    logic        rsv_valid = 1'b0;
    logic [3:0]  rsv_rd = '0;
    logic [15:0] busy;

    int n_checks = 0;
    int n_pass   = 0;

    regbank_wr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_rd   (req0_rd),
        .req0_wd   (req0_wd),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_rd   (req1_rd),
        .req1_wd   (req1_wd),
        .req1_ready(req1_ready),
        .WE        (WE),
        .Rd        (Rd),
        .WD        (WD),
        .grant_id  (grant_id),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register bank fed by the arbiter, written on the falling edge.
    logic [31:0] bank [16] = '{default: 32'h0};
    always @(negedge clk) begin
        if (WE && Rd != 4'd0) bank[Rd] <= WD;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int winner(input logic a, input logic b, input logic last);
        if (a && b) return last ? 0 : 1;
        if (a) return 0;
        if (b) return 1;
        return -1;
    endfunction

    function automatic logic [15:0] next_busy(input logic [15:0] cur, input logic acc,
                                              input logic [3:0] wrd, input logic rv,
                                              input logic [3:0] rr);
        logic [15:0] b = cur;
        if (acc && wrd != 0) b[wrd] = 1'b0;
        if (SB && rv && rr != 0) b[rr] = 1'b1;
        return b;
    endfunction

    logic        m_last = 1'b1;
    logic        m_we = 1'b0;
    logic [3:0]  m_rd = '0;
    logic [31:0] m_wd = '0;
    logic        m_gid = 1'b0;
    logic [15:0] m_busy = '0;

    logic        m_acc, m_w1;
    logic [3:0]  m_wrd;
    logic [31:0] m_wwd;
    assign m_acc = rst && (winner(req0_valid, req1_valid, m_last) >= 0);
    assign m_w1  = (winner(req0_valid, req1_valid, m_last) == 1);
    assign m_wrd = m_w1 ? req1_rd : req0_rd;
    assign m_wwd = m_w1 ? req1_wd : req0_wd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_last <= 1'b1;
            m_we   <= 1'b0;
            m_rd   <= '0;
            m_wd   <= '0;
            m_gid  <= 1'b0;
            m_busy <= '0;
        end else begin
            m_we   <= m_acc && (m_wrd != 0);
            m_busy <= next_busy(m_busy, m_acc, m_wrd, rsv_valid, rsv_rd);
            if (m_acc) begin
                m_last <= m_w1;
                m_rd   <= m_wrd;
                m_wd   <= m_wwd;
                m_gid  <= m_w1;
            end
        end
    end

    always @(negedge clk) begin
        chk("req0_ready", req0_ready, m_acc && !m_w1);
        chk("req1_ready", req1_ready, m_acc && m_w1);
        chk("WE", WE, m_we);
        chk("Rd", Rd, m_rd);
        chk("WD", WD, m_wd);
        chk("grant_id", grant_id, m_gid);
        chk("busy", busy, m_busy);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with both requesters valid.
        req0_valid = 1'b1; req0_rd = 4'd2; req0_wd = 32'h5;
        req1_valid = 1'b1; req1_rd = 4'd6; req1_wd = 32'h6;
        step();
        chk("rst_WE", WE, 1'b0);
        chk("rst_Rd", Rd, 4'd0);
        chk("rst_WD", WD, 32'h0);
        chk("rst_busy", busy, 16'h0);
        chk("rst_readys", {req0_ready, req1_ready}, 2'b00);
        step();
        rst = 1'b1;
        #1;
        chk("first_tie_readys", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Single requester.
        step();
        req0_valid = 1'b1; req0_rd = 4'd5; req0_wd = 32'hDEADBEEF;
        #1;
        chk("single_ready", req0_ready, 1'b1);
        step();
        req0_valid = 1'b0;
        chk("single_WE", WE, 1'b1);
        chk("single_Rd", Rd, 4'd5);
        chk("single_WD", WD, 32'hDEADBEEF);
        chk("single_gid", grant_id, 1'b0);
        @(negedge clk);
        #1;
        chk("bank5", bank[5], 32'hDEADBEEF);

        // Index 0 from requester 1.
        step();
        req1_valid = 1'b1; req1_rd = 4'd0; req1_wd = 32'h1234;
        #1;
        chk("idx0_ready", req1_ready, 1'b1);
        step();
        req1_valid = 1'b0;
        chk("idx0_WE", WE, 1'b0);
        chk("idx0_gid", grant_id, 1'b1);
        @(negedge clk);
        #1;
        chk("bank0", bank[0], 32'h0);

        // Contention: grants alternate starting with requester 0.
        step();
        req0_valid = 1'b1; req0_rd = 4'd3; req0_wd = 32'hA0A0A0A0;
        req1_valid = 1'b1; req1_rd = 4'd7; req1_wd = 32'hB1B1B1B1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("cont_gid", grant_id, (i % 2));
            chk("cont_Rd", Rd, (i % 2) ? 4'd7 : 4'd3);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Scoreboard reserve / same-edge reserve+clear / clear.
        step();
        rsv_valid = 1'b1; rsv_rd = 4'd9;
        step();
        rsv_valid = 1'b0;
        chk("sb_reserve", busy[9], SB);
        req0_valid = 1'b1; req0_rd = 4'd9; req0_wd = 32'h99;
        rsv_valid = 1'b1; rsv_rd = 4'd9;
        step();
        req0_valid = 1'b0; rsv_valid = 1'b0;
        chk("sb_rsv_wins", busy[9], SB);
        req1_valid = 1'b1; req1_rd = 4'd9; req1_wd = 32'h999;
        step();
        req1_valid = 1'b0;
        chk("sb_clear", busy[9], 1'b0);
        chk("sb_bit0", busy[0], 1'b0);

        // Reset mid-operation drops the launched write.
        step();
        req0_valid = 1'b1; req0_rd = 4'd4; req0_wd = 32'h11111111;
        step();
        req0_wd = 32'h22222222;
        step();
        req0_valid = 1'b0;
        chk("pre_rst_WE", WE, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_WE", WE, 1'b0);
        @(negedge clk);
        #1;
        chk("bank4_kept", bank[4], 32'h11111111);
        step();
        rst = 1'b1;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regbank_wr_arbiter.md
# regbank_wr_arbiter

Write-port arbiter and scheduler for the single-write-port register bank (16 × 32-bit, write on falling clock edge, index 0 never written). It sits between two writeback sources and the bank's `WE`/`Rd`/`WD` inputs. Requester 0 is the ALU writeback and requester 1 is the memory-load writeback. It grants at most one write per cycle using round-robin arbitration, launches the winning write from registers, and optionally keeps a busy scoreboard for the issue stage's hazard stall.

## Interface
Parameters:
- `Index_size`, default 4: register index width; the bank holds 2**Index_size registers.
- `width`, default 32: data width.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a write pending.
- `req0_rd` in Index_size: destination index for requester 0.
- `req0_wd` in width: write data for requester 0.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req1_valid`, `req1_rd`, `req1_wd`, `req1_ready`: same meanings for requester 1.
- `WE` out 1: registered write enable to the bank.
- `Rd` out Index_size: registered write index to the bank.
- `WD` out width: registered write data to the bank.
- `grant_id` out 1: registered ID of the requester whose write is on `WE`/`Rd`/`WD`.
- `rsv_valid` in 1: issue stage reserves a destination register (scoreboard build only).
- `rsv_rd` in Index_size: index being reserved.
- `busy` out 2**Index_size: per-register pending-write bits.

## Operation
Handshake:
- A transfer happens on a rising edge where `reqN_valid` and `reqN_ready` are both 1.
- A requester holds `valid`, `rd` and `wd` stable until it is accepted.
- `reqN_valid` must not depend on `reqN_ready`.
- `ready` is combinational from the two valids and the arbitration pointer.

Arbitration:
- Only one requester is valid: it gets ready.
- Both requesters are valid: the one not granted last wins.
- `req0_ready` and `req1_ready` are never both 1.
- The 1-bit pointer `last` updates to the winner's ID on every accepted transfer and holds otherwise.
- Reset sets `last` = 1, so requester 0 wins the first tie.

Launch:
- On an accepted transfer, `WE` <= (rd != 0), `Rd` <= rd, `WD` <= wd, `grant_id` <= winner.
- With no transfer, `WE` <= 0; `Rd`, `WD` and `grant_id` hold.
- A write to index 0 is still accepted (ready = 1) but launches with `WE` = 0.

Scoreboard (only with the macro defined):
- On `rsv_valid` with `rsv_rd` != 0, `busy[rsv_rd]` is set at the next edge.
- An accepted transfer to index rd != 0 clears `busy[rd]` at the same edge it is accepted.
- Reserve and clear of the same index on the same edge: the reserve wins and the bit stays 1, because a newer writer is pending.
- `busy[0]` is always 0.
- A reserve of an already-busy register leaves it busy; the issue stage must stall on `busy` and never double-reserve.

Reset (`rst` low, asynchronous):
- `WE` = 0, `Rd` = 0, `WD` = 0, `grant_id` = 0, `last` = 1, `busy` = 0.
- `ready` outputs follow the combinational rule during reset: both are 0 while `rst` is low.
- Reset asserted mid-transfer drops any launched write; the dropped write does not reach the bank.

## Timing
- Accept at rising edge N: `WE`/`Rd`/`WD` are valid from edge N until edge N+1.
- The bank captures the write at the falling edge inside cycle N+1.
- The written value is readable combinationally after that falling edge.
- Latency: 1 cycle from acceptance to the bank write.
- Throughput: 1 write per cycle; with continuous contention each requester gets 1 write every 2 cycles.
- `busy` changes only on rising edges, so it is stable for a full cycle for the stall logic.

## Configuration
- `REGBANK_WR_ARB_SCOREBOARD_EN` defined: the `busy` vector and the reserve/clear logic are compiled in.
- Undefined: `rsv_valid` and `rsv_rd` are ignored, `busy` is tied to 0, and no scoreboard flops exist.
- Arbitration and launch behaviour are identical in both builds.

## Test plan
- **Reset:** hold `rst` = 0 with both valids = 1 -> `WE` = 0, `Rd` = 0, `WD` = 0, `busy` = 0, both readys = 0. Release `rst` -> requester 0 is granted first.
- **Single requester:** `req0` writes rd = 5, wd = 0xDEADBEEF -> `req0_ready` = 1. The next cycle shows `WE` = 1, `Rd` = 5, `WD` = 0xDEADBEEF, `grant_id` = 0. Bank register 5 reads 0xDEADBEEF after the falling edge.
- **Contention:** both requesters valid for 4 cycles (rd = 3 and rd = 7) -> grants alternate 0,1,0,1 and `Rd` alternates 3,7,3,7.
- **Index 0:** `req1` writes rd = 0, wd = 0x1234 -> `req1_ready` = 1, `WE` stays 0, register 0 reads 0.
- **Scoreboard:** reserve rd = 9 -> `busy[9]` = 1. On the same edge that `req0` writing rd = 9 is accepted, reserve rd = 9 again -> `busy[9]` stays 1. Then accept `req1` to rd = 9 -> `busy[9]` = 0.
- **Reset mid-operation:** assert `rst` low asynchronously while `WE` = 1 -> `WE` drops to 0 immediately and the bank register keeps its old value.
